// File: rtl/priority_scan_engine.sv
// Iterative priority scanner: loads a request vector and emits set-bit indices, highest first.
// Optional PSCAN_COUNT_EN adds a setCount popcount register captured on each load.
module priority_scan_engine #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [WIDTH-1:0]          inVec,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [$clog2(WIDTH)-1:0]  outIdx,
    output logic                      outLast,
    output logic                      outNone,
    output logic                      busy
`ifdef PSCAN_COUNT_EN
    ,
    output logic [$clog2(WIDTH):0]    setCount
`endif
);

    localparam int IDXW = $clog2(WIDTH);
    localparam int P    = 1 << IDXW;

    typedef enum logic [1:0] {IDLE, SCAN, NONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  pend;
    logic [IDXW-1:0]   hi_idx;
    logic              pend_one;

    // Balanced tree over a power-of-two padded copy; the upper child wins each node.
    always_comb begin
        logic [P-1:0]    v;
        logic [IDXW-1:0] ix [P];
        v = P'(pend);
        for (int unsigned n = 0; n < P; n++) ix[n] = IDXW'(n);
        for (int unsigned l = 0; l < IDXW; l++) begin
            for (int unsigned n = 0; n < (P >> (l + 1)); n++) begin
                ix[n] = v[2*n+1] ? ix[2*n+1] : ix[2*n];
                v[n]  = v[2*n] | v[2*n+1];
            end
        end
        hi_idx = ix[0];
    end

    assign pend_one = (pend != '0) && ((pend & (pend - 1'b1)) == '0);

    assign inReady = (state == IDLE) && !reset;
    assign outIdx  = (state == SCAN) ? hi_idx : '0;
    assign outLast = ((state == SCAN) && pend_one) || (state == NONE);

`ifdef PSCAN_COUNT_EN
    function automatic logic [IDXW:0] popcnt(input logic [WIDTH-1:0] vec);
        logic [IDXW:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) c = c + (IDXW+1)'(vec[i]);
        return c;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pend     <= '0;
            outValid <= 1'b0;
            outNone  <= 1'b0;
            busy     <= 1'b0;
`ifdef PSCAN_COUNT_EN
            setCount <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        pend     <= inVec;
                        outValid <= 1'b1;
                        busy     <= 1'b1;
`ifdef PSCAN_COUNT_EN
                        setCount <= popcnt(inVec);
`endif
                        if (inVec != '0) begin
                            state   <= SCAN;
                            outNone <= 1'b0;
                        end else begin
                            state   <= NONE;
                            outNone <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (outReady) begin
                        pend <= pend & ~(WIDTH'(1) << hi_idx);
                        if (pend_one) begin
                            state    <= IDLE;
                            outValid <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                NONE: begin
                    if (outReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                        outNone  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                    outNone  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_scan_engine.sv
// Directed bench for priority_scan_engine: WIDTH=32 vector table plus WIDTH=5 and mid-scan reset sequences.
module tb_priority_scan_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid, inReady, outValid, outReady, outLast, outNone, busy;
    logic [31:0] inVec;
    logic [4:0]  outIdx;
    logic        v5_inValid, v5_inReady, v5_outValid, v5_outReady, v5_outLast, v5_outNone, v5_busy;
    logic [4:0]  v5_inVec;
    logic [2:0]  v5_outIdx;
`ifdef PSCAN_COUNT_EN
    logic [5:0]  setCount;
    logic [3:0]  v5_setCount;
`endif

    priority_scan_engine #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inVec(inVec),
        .outValid(outValid), .outReady(outReady), .outIdx(outIdx), .outLast(outLast),
        .outNone(outNone), .busy(busy)
`ifdef PSCAN_COUNT_EN
        , .setCount(setCount)
`endif
    );

    priority_scan_engine #(.WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .inValid(v5_inValid), .inReady(v5_inReady), .inVec(v5_inVec),
        .outValid(v5_outValid), .outReady(v5_outReady), .outIdx(v5_outIdx), .outLast(v5_outLast),
        .outNone(v5_outNone), .busy(v5_busy)
`ifdef PSCAN_COUNT_EN
        , .setCount(v5_setCount)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0]      vec;
        logic [7:0]       rdy;   // outReady per cycle after load, bit c = cycle c
        int unsigned      n;
        logic [3:0][7:0]  e;
        int unsigned      cnt;
        int unsigned      done;  // cycle after load at which IDLE is expected
    } rec_t;

    function automatic rec_t mk(input logic [31:0] v, input logic [7:0] rdy, input int unsigned n,
                                input int unsigned a, input int unsigned b, input int unsigned c,
                                input int unsigned d, input int unsigned cnt, input int unsigned done);
        rec_t r;
        r.vec = v; r.rdy = rdy; r.n = n; r.cnt = cnt; r.done = done;
        r.e[0] = 8'(a); r.e[1] = 8'(b); r.e[2] = 8'(c); r.e[3] = 8'(d);
        return r;
    endfunction

    rec_t tbl[5];

    task automatic run_vec(input rec_t r);
        int unsigned beat;
        int unsigned c;
        @(negedge clk);
        chk("idle_inReady", 32'(inReady), 1);
        chk("idle_outValid", 32'(outValid), 0);
        inVec   = r.vec;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        beat = 0;
        c    = 0;
        while (beat < r.n && c < 64) begin
            outReady = (c < 8) ? r.rdy[c] : 1'b1;
            chk("beat_valid", 32'(outValid), 1);
            chk("beat_busy", 32'(busy), 1);
            chk("beat_inReady", 32'(inReady), 0);
`ifdef PSCAN_COUNT_EN
            chk("setCount", 32'(setCount), r.cnt);
`endif
            chk("beat_idx", 32'(outIdx), 32'(r.e[beat]));
            chk("beat_none", 32'(outNone), (r.vec == 0) ? 1 : 0);
            chk("beat_last", 32'(outLast), (beat == r.n - 1) ? 1 : 0);
            if (outValid && outReady) beat++;
            @(negedge clk);
            c++;
        end
        outReady = 1'b0;
        chk("beat_count", beat, r.n);
        chk("done_cycle", c, r.done);
        chk("end_outValid", 32'(outValid), 0);
        chk("end_inReady", 32'(inReady), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_idx_last_none", {outIdx, outLast, outNone}, 0);
    endtask

    initial begin
        int unsigned exp5[3];
        tbl[0] = mk(32'h8000_0001, 8'hFF, 2, 31, 0, 0, 0, 2, 2);
        tbl[1] = mk(32'h0000_0000, 8'hFF, 1, 0, 0, 0, 0, 0, 1);
        tbl[2] = mk(32'h0000_00F0, 8'hF9, 4, 7, 6, 5, 4, 4, 6);
        tbl[3] = mk(32'h0000_0001, 8'hFF, 1, 0, 0, 0, 0, 1, 1);
        tbl[4] = mk(32'h0001_2000, 8'hFF, 2, 16, 13, 0, 0, 2, 2);
        exp5[0] = 4; exp5[1] = 2; exp5[2] = 0;

        reset = 1'b0; inValid = 1'b0; outReady = 1'b0; inVec = '0;
        v5_inValid = 1'b0; v5_outReady = 1'b0; v5_inVec = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_inReady", 32'(inReady), 0);
        chk("rst_outs", {outValid, outIdx, outLast, outNone, busy}, 0);
        chk("rst5_outs", {v5_inReady, v5_outValid, v5_outIdx, v5_outLast, v5_outNone, v5_busy}, 0);
`ifdef PSCAN_COUNT_EN
        chk("rst_setCount", 32'(setCount), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // All-ones vector: 32 back-to-back beats
        @(negedge clk);
        inVec = 32'hFFFF_FFFF; inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("ones_valid", 32'(outValid), 1);
            chk("ones_idx", 32'(outIdx), 32'(31 - i));
            chk("ones_last", 32'(outLast), (i == 31) ? 1 : 0);
`ifdef PSCAN_COUNT_EN
            chk("ones_setCount", 32'(setCount), 32);
`endif
            @(negedge clk);
        end
        chk("ones_idle", {outValid, inReady, busy}, 32'b010);
        outReady = 1'b0;

        // Mid-scan asynchronous reset
        @(negedge clk);
        inVec = 32'h0000_0F00; inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b1;
        chk("rs_idx11", 32'(outIdx), 11);
        @(negedge clk);
        chk("rs_idx10", 32'(outIdx), 10);
        @(negedge clk);
        chk("rs_idx9_pending", 32'(outIdx), 9);
        outReady = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rs_outs_zero", {outValid, outIdx, outLast, outNone, busy}, 0);
        chk("rs_inReady", 32'(inReady), 0);
        @(negedge clk);
        chk("rs_held_inReady", 32'(inReady), 0);
        chk("rs_held_valid", 32'(outValid), 0);
        reset = 1'b0; outReady = 1'b1;
        #1 chk("rs_release_inReady", 32'(inReady), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rs_no_stale", {outValid, busy, outIdx}, 0);
            chk("rs_inReady_after", 32'(inReady), 1);
        end
        outReady = 1'b0;

        // WIDTH=5 with inValid held through the scan
        @(negedge clk);
        chk("w5_inReady", 32'(v5_inReady), 1);
        v5_inVec = 5'b10101; v5_inValid = 1'b1;
        @(negedge clk);
        v5_inVec = 5'b11111; v5_outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("w5_valid", 32'(v5_outValid), 1);
            chk("w5_inReady_busy", 32'(v5_inReady), 0);
            chk("w5_idx", 32'(v5_outIdx), exp5[i]);
            chk("w5_last", 32'(v5_outLast), (i == 2) ? 1 : 0);
            chk("w5_none", 32'(v5_outNone), 0);
`ifdef PSCAN_COUNT_EN
            chk("w5_setCount", 32'(v5_setCount), 3);
`endif
            @(negedge clk);
        end
        chk("w5_idle", {v5_outValid, v5_inReady, v5_busy}, 32'b010);
        v5_inValid = 1'b0; v5_outReady = 1'b0;
        @(negedge clk);
        chk("w5_stay_idle", {v5_outValid, v5_busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
